// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder: format codes, FSM states,
// the NOP substitute word and the opcode legality helper.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_S = 2'b10,
    FMT_B = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
  localparam logic [1:0]  OPC_LEGAL_LSB = 2'b11;
  localparam logic [31:0] ADDR_STEP     = 32'd4;
  localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

  // 32-bit base-ISA opcodes always end in 2'b11; anything else is rejected.
  function automatic logic opcode_legal(input logic [6:0] op);
    return (op[1:0] == OPC_LEGAL_LSB);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  // Encoder side: consumes bundles, drives memory writes.
  modport slave (
    input  in_valid, in_last, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  // Environment side: produces bundles, sinks memory writes.
  modport master (
    output in_valid, in_last, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_encoder_packer.sv
// Purely combinational packing of instruction fields into a 32-bit word.
module instr_packer
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  // Select bit layout by format; for B the imm input holds offset bits [12:1].
  always_comb begin
    word = 32'h0000_0000;
    case (fmt_e'(fmt))
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      default: word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Burst instruction encoder: accepts field bundles, packs them and writes
// them to consecutive instruction-memory words through a single output
// register that keeps one write in flight with full throughput.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    base_addr,
  instr_encoder_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [15:0]    count
);

  state_e      state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        in_ready_s;
  logic        accept_s;
  logic        retire_s;
  logic [31:0] packed_s;

  instr_packer u_packer (
    .fmt    (bus.fmt),
    .opcode (bus.opcode),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .rd     (bus.rd),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .imm    (bus.imm),
    .word   (packed_s)
  );

  // Handshake: new bundle accepted only in RUN when the output register frees up this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_q == ST_RUN) begin
      in_ready_s = !mem_we_q || bus.mem_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_ready_s && bus.in_valid;
    retire_s = mem_we_q && bus.mem_ready;
  end

  // Next-state logic for the burst FSM and the one-cycle done pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && bus.in_last) state_d = ST_FLUSH;
        else                         state_d = ST_RUN;
      end
      ST_FLUSH: begin
        if (retire_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: address/count/err updates and output-register load; retire and load may coincide.
  always_comb begin
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    mem_we_d = mem_we_q;
    if ((state_q == ST_IDLE) && start) begin
      addr_d  = base_addr;
      count_d = 16'h0000;
      err_d   = 1'b0;
    end else begin
      if (retire_s) begin
        addr_d   = addr_q + ADDR_STEP;
        count_d  = (count_q == COUNT_MAX) ? COUNT_MAX : (count_q + 16'd1);
        mem_we_d = 1'b0;
      end else begin
        addr_d = addr_q;
      end
      if (accept_s) begin
        mem_we_d = 1'b1;
        if (opcode_legal(bus.opcode)) begin
          wdata_d = packed_s;
        end else begin
          wdata_d = NOP_WORD;
          err_d   = 1'b1;
        end
      end else begin
        wdata_d = wdata_q;
      end
    end
  end

  // State and output registers; reset drops any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mem_we_q <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      count_q  <= 16'h0000;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign count         = count_q;

endmodule
